uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter fed from an upstream FIFO.
// Handshake: a byte moves on any rising edge where din_vld & din_rdy.
// din_rdy is combinational from state and tx_en only (never from din_vld),
// so it is safe to wire straight to the FIFO pop input.
// The divisor, stop-bit mode and data byte are latched on that edge,
// so input changes during a frame affect only later frames.
`timescale 1ns/1ps
module uart_tx #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             stop2,
   input  logic [7:0]       din,
   input  logic             din_vld,
   output logic             din_rdy,
   output logic             txd,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [DIV_W-1:0] div_q, div_n;
   logic             stop2_q, stop2_n;
   logic [7:0]       data_q, data_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [2:0]       next_idx;
   logic             stop_idx, stop_idx_n;
   logic             txd_q, txd_n;
   logic             bit_end;
   logic             last_stop;
   logic             accept;

   // A bit period ends when the down-counter, loaded with the latched
   // divisor, has reached zero; the final stop bit is the one whose index
   // matches the latched stop2 mode.
   assign bit_end   = (cnt == '0);
   assign last_stop = (state == STOP) && bit_end && (stop_idx == stop2_q);
   assign next_idx  = bit_idx + 3'd1;

   assign din_rdy = ~rst & tx_en & ((state == IDLE) | last_stop);
   assign accept  = din_vld & din_rdy;
   assign done    = ~rst & last_stop;
   assign busy    = (state != IDLE);
   assign txd     = txd_q;

   // Next-state and datapath logic; everything holds unless updated below.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      div_n      = div_q;
      stop2_n    = stop2_q;
      data_n     = data_q;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      txd_n      = txd_q;
      case (state)
         IDLE: begin
            txd_n = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               cnt_n     = div_q;
               bit_idx_n = 3'd0;
               txd_n     = data_q[0];
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = div_q;
               if (bit_idx == 3'd7) begin
                  state_n    = STOP;
                  stop_idx_n = 1'b0;
                  txd_n      = 1'b1;
               end else begin
                  bit_idx_n = next_idx;
                  txd_n     = data_q[next_idx];
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         STOP: begin
            txd_n = 1'b1;
            if (bit_end) begin
               if (stop_idx != stop2_q) begin
                  stop_idx_n = 1'b1;
                  cnt_n      = div_q;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            txd_n   = 1'b1;
         end
      endcase
      // An accepted byte (from IDLE or the last stop cycle) starts a frame
      // immediately, giving back-to-back frames with no idle gap.
      if (accept) begin
         state_n    = START;
         cnt_n      = baud_div;
         div_n      = baud_div;
         stop2_n    = stop2;
         data_n     = din;
         bit_idx_n  = 3'd0;
         stop_idx_n = 1'b0;
         txd_n      = 1'b0;
      end
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         div_q    <= '0;
         stop2_q  <= 1'b0;
         data_q   <= 8'h00;
         bit_idx  <= 3'd0;
         stop_idx <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_q    <= div_n;
         stop2_q  <= stop2_n;
         data_q   <= data_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         txd_q    <= txd_n;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: frame-shape table, directed multi-cycle sequences,
// a cycle-level line model and a random byte stream decoded from txd.
`timescale 1ns/1ps
module tb_uart_tx;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst, tx_en, stop2, din_vld;
   logic       din_rdy, txd, busy, done;
   logic [3:0] baud_div;
   logic [7:0] din;

   always #5 clk = ~clk;

   uart_tx #(.DIV_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_en    (tx_en),
      .baud_div (baud_div),
      .stop2    (stop2),
      .din      (din),
      .din_vld  (din_vld),
      .din_rdy  (din_rdy),
      .txd      (txd),
      .busy     (busy),
      .done     (done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // line_q holds the expected txd value of every future cycle of the frames
   // accepted so far; a frame is start, 8 data bits LSB first, 1 or 2 stops,
   // each repeated div+1 times.
   typedef struct {
      logic [3:0] div;
      logic [7:0] data;
   } byte_rec_t;

   logic      line_q[$];
   byte_rec_t exp_q[$];
   logic      model_en = 1'b0;
   logic      dec_en = 1'b0;
   int        mn;
   logic      e_txd, e_busy, e_done, e_rdy;

   function automatic void push_frame(input logic [7:0] data, input logic [3:0] div, input logic s2);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      foreach (bits[b])
         for (int r = 0; r <= int'(div); r++) line_q.push_back(bits[b]);
   endfunction

   always @(negedge clk) begin
      if (model_en) begin
         mn     = line_q.size();
         e_txd  = (mn > 0) ? line_q[0] : 1'b1;
         e_busy = (mn > 0);
         e_done = (mn == 1) && !rst;
         e_rdy  = tx_en && !rst && (mn <= 1);
         check("m_txd",  32'(txd),     32'(e_txd));
         check("m_busy", 32'(busy),    32'(e_busy));
         check("m_done", 32'(done),    32'(e_done));
         check("m_rdy",  32'(din_rdy), 32'(e_rdy));
         if (mn > 0) void'(line_q.pop_front());
         if (rst) line_q.delete();
         else if (din_vld && e_rdy) begin
            push_frame(din, baud_div, stop2);
            if (dec_en) exp_q.push_back('{div: baud_div, data: din});
         end
      end
   end

   // ---------------- line decoder / scoreboard ----------------
   int         dec_count = 0;
   logic       dec_active = 1'b0;
   byte_rec_t  dec_ent;
   logic [7:0] dec_val;

   always begin
      @(negedge clk);
      if (dec_en && txd === 1'b0) begin
         dec_active = 1'b1;
         if (exp_q.size() == 0) begin
            check("dec_unexpected_start", 32'd0, 32'd1);
         end else begin
            dec_ent = exp_q[0];
            repeat (int'(dec_ent.div) / 2) @(negedge clk);
            check("dec_start", 32'(txd), 32'd0);
            for (int b = 0; b < 8; b++) begin
               repeat (int'(dec_ent.div) + 1) @(negedge clk);
               dec_val[b] = txd;
            end
            repeat (int'(dec_ent.div) + 1) @(negedge clk);
            check("dec_stop", 32'(txd), 32'd1);
            check("dec_byte", 32'(dec_val), 32'(dec_ent.data));
            void'(exp_q.pop_front());
            dec_count++;
         end
         dec_active = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for din_rdy; returns at the negedge before the accept edge.
   task automatic wait_rdy(output int n, input bit jitter);
      n = 0;
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (din_rdy === 1'b1) begin
            n = i;
            break;
         end
         tick();
         if (jitter) begin
            baud_div = 4'($urandom_range(0, 15));
            stop2    = 1'($urandom_range(0, 1));
         end
      end
      if (n == 0) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int ok;
      ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) check("idle_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // Send one byte from idle and measure the frame: length in cycles after the
   // accept edge, cycle of done, number of done pulses and mid-bit txd samples
   // (bits[9] is the first bit on the line).
   task automatic send_measure(input logic [7:0] data, input logic [3:0] div, input logic s2,
                               output int len, output int done_at, output int done_n,
                               output logic [9:0] bits, output int wait_n);
      din = data; baud_div = div; stop2 = s2; din_vld = 1'b1; tx_en = 1'b1;
      wait_rdy(wait_n, 1'b0);
      tick();
      din_vld = 1'b0;
      len = 0; done_at = 0; done_n = 0; bits = '1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (busy !== 1'b1) begin
            len = k - 1;
            break;
         end
         if (done === 1'b1) begin
            done_at = k;
            done_n++;
         end
         for (int b = 0; b < 10; b++)
            if (k == b * (int'(div) + 1) + 1 + int'(div) / 2) bits[9 - b] = txd;
      end
      tick();
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      logic [7:0] data;
      logic [3:0] div;
      logic       s2;
      int         exp_len;
      logic [9:0] exp_bits;
   } vec_t;

   vec_t       vecs[6];
   int         len, done_at, done_n, w, p, acc_n, busy_run, d1, d2, ndone, endk, rdy_n;
   logic [9:0] bits;
   logic       acc;
   logic [7:0] fifo[3];

   initial begin
      vecs[0] = '{data: 8'hA5, div: 4'd3,  s2: 1'b0, exp_len: 40,  exp_bits: 10'b0101001011};
      vecs[1] = '{data: 8'h80, div: 4'd1,  s2: 1'b1, exp_len: 22,  exp_bits: 10'b0000000011};
      vecs[2] = '{data: 8'h00, div: 4'd0,  s2: 1'b0, exp_len: 10,  exp_bits: 10'b0000000001};
      vecs[3] = '{data: 8'hFF, div: 4'd0,  s2: 1'b1, exp_len: 11,  exp_bits: 10'b0111111111};
      vecs[4] = '{data: 8'h3C, div: 4'd7,  s2: 1'b0, exp_len: 80,  exp_bits: 10'b0001111001};
      vecs[5] = '{data: 8'h5A, div: 4'd15, s2: 1'b1, exp_len: 176, exp_bits: 10'b0010110101};
      fifo[0] = 8'h00; fifo[1] = 8'hFF; fifo[2] = 8'h3C;

      rst = 1'b1; tx_en = 1'b0; stop2 = 1'b0; din_vld = 1'b0; din = 8'h00; baud_div = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      model_en = 1'b1;
      @(negedge clk);
      check("rst_txd",  32'(txd),     32'd1);
      check("rst_busy", 32'(busy),    32'd0);
      check("rst_done", 32'(done),    32'd0);
      check("rst_rdy",  32'(din_rdy), 32'd0);
      tick();
      rst = 1'b0;

      // Frame shapes; the first accept must land on the first edge after reset.
      for (int i = 0; i < 6; i++) begin
         send_measure(vecs[i].data, vecs[i].div, vecs[i].s2, len, done_at, done_n, bits, w);
         if (i == 0) check("first_accept_wait", 32'(w), 32'd1);
         check("frame_len",  32'(len),     32'(vecs[i].exp_len));
         check("done_cycle", 32'(done_at), 32'(vecs[i].exp_len));
         check("done_count", 32'(done_n),  32'd1);
         check("frame_bits", 32'(bits),    32'(vecs[i].exp_bits));
         wait_idle();
      end

      // Preloaded FIFO, baud_div=0: three back-to-back 10-cycle frames.
      p = 0; acc_n = 0; busy_run = 0;
      din = fifo[0]; din_vld = 1'b1; baud_div = 4'd0; stop2 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_run++;
         else if (busy_run > 0) break;
         acc = din_vld && din_rdy;
         if (acc) acc_n++;
         tick();
         if (acc) begin
            p++;
            if (p < 3) din = fifo[p];
            else din_vld = 1'b0;
         end
      end
      check("fifo_accepts",  32'(acc_n),    32'd3);
      check("fifo_busy_run", 32'(busy_run), 32'd30);
      check("fifo_empty",    32'(p),        32'd3);
      wait_idle();

      // Divisor and stop mode changed mid-frame: only the next frame sees them.
      din = 8'h5A; baud_div = 4'd3; stop2 = 1'b0; din_vld = 1'b1;
      wait_rdy(w, 1'b0);
      tick();
      din = 8'hC3;
      d1 = 0; d2 = 0; ndone = 0; endk = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) d1 = k; else d2 = k;
         end
         if (busy !== 1'b1) begin
            endk = k;
            break;
         end
         acc = din_vld && din_rdy;
         tick();
         if (k == 10) begin baud_div = 4'd7; stop2 = 1'b1; end
         if (acc) din_vld = 1'b0;
      end
      check("chg_done1", 32'(d1),   32'd40);
      check("chg_done2", 32'(d2),   32'd128);
      check("chg_end",   32'(endk), 32'd129);
      wait_idle();

      // tx_en dropped during data bit 3: frame completes, no further accept.
      din = 8'h55; baud_div = 4'd3; stop2 = 1'b0; din_vld = 1'b1; tx_en = 1'b1;
      wait_rdy(w, 1'b0);
      tick();
      din = 8'h96;
      rdy_n = 0; done_at = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (din_rdy === 1'b1) rdy_n++;
         if (done === 1'b1) done_at = k;
         tick();
         if (k == 18) tx_en = 1'b0;
      end
      @(negedge clk);
      check("en_done_cycle", 32'(done_at), 32'd40);
      check("en_rdy_held",   32'(rdy_n),   32'd0);
      check("en_idle",       32'(busy),    32'd0);
      tick();
      tx_en = 1'b1;
      wait_rdy(w, 1'b0);
      check("en_resume_wait", 32'(w), 32'd1);
      tick();
      din_vld = 1'b0;
      @(negedge clk);
      check("en_resume_busy", 32'(busy), 32'd1);
      check("en_resume_txd",  32'(txd),  32'd0);
      wait_idle();

      // Reset pulse during data bit 5 aborts the frame.
      din = 8'h3C; baud_div = 4'd3; stop2 = 1'b0; din_vld = 1'b1;
      wait_rdy(w, 1'b0);
      tick();
      din_vld = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_txd",  32'(txd),  32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      tick();
      send_measure(8'hA5, 4'd3, 1'b0, len, done_at, done_n, bits, w);
      check("post_abort_len",  32'(len),     32'd40);
      check("post_abort_bits", 32'(bits),    32'(10'b0101001011));
      check("post_abort_done", 32'(done_at), 32'd40);
      wait_idle();

      // Random stream: 512 bytes, random throttling, divisor and stop mode.
      dec_en = 1'b1;
      for (int n = 0; n < 512; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            din_vld = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
         end
         din      = 8'($urandom);
         baud_div = 4'($urandom_range(0, 15));
         stop2    = 1'($urandom_range(0, 1));
         din_vld  = 1'b1;
         wait_rdy(w, 1'b1);
         tick();
      end
      din_vld = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !dec_active && busy === 1'b0) break;
      end
      check("stream_decoded", 32'(dec_count),    32'd512);
      check("stream_pending", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      repeat (95000) @(posedge clk);
      check("watchdog", 32'd0, 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
